// File: rtl/vslc_scan_sequencer.sv
// VSLC scan-cycle scheduler: sample -> exec -> commit -> wait loop.
// Optional watchdog: define VSLC_SCAN_WATCHDOG_EN.
module vslc_scan_sequencer #(
  parameter int ADDR_W      = 5,
  parameter int PROG_LEN    = 32,
  parameter int PERIOD_W    = 16,
  parameter int SCAN_PERIOD = 1200
`ifdef VSLC_SCAN_WATCHDOG_EN
  ,
  parameter int WDT_CYCLES  = 255
`endif
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              en,
  input  logic              clr_flags,
  input  logic [7:0]        ui_in,
  input  logic              step_ack,
  input  logic              halt,
  input  logic [7:0]        out_image_d,
  output logic [7:0]        in_image,
  output logic [ADDR_W-1:0] pc,
  output logic              step_req,
  output logic              addr_strobe,
  output logic [7:0]        uo_out,
  output logic              scan_cycle_clk,
  output logic              overrun,
  output logic              fault
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SAMPLE,
    S_EXEC,
    S_COMMIT,
    S_WAIT
  } state_t;

  localparam logic [ADDR_W-1:0] PC_LAST =
    ADDR_W'(PROG_LEN - 1);
  // Reload on the edge into SAMPLE so that
  // SAMPLE-to-SAMPLE spacing is SCAN_PERIOD.
  localparam logic [PERIOD_W-1:0] RELOAD =
    PERIOD_W'(SCAN_PERIOD - 1);

  state_t state_q, state_d;

  logic [PERIOD_W-1:0] timer_q;
  logic [ADDR_W-1:0]   pc_q;
  logic [7:0]          in_q;
  logic [7:0]          uo_q;
  logic                strobe_q;
  logic                ovr_q;
  logic                fault_q;
  logic                wdt_trip;

  logic t_zero;
  logic in_exec;
  logic last_step;
  logic adv;
  logic ovr_set;

  assign t_zero    = (timer_q == '0);
  assign in_exec   = (state_q == S_EXEC);
  assign last_step = halt || (pc_q == PC_LAST);
  assign adv       = in_exec && step_ack
                     && !last_step;
  assign ovr_set   = t_zero
                     && (in_exec
                     || state_q == S_SAMPLE);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (en) state_d = S_SAMPLE;
      end
      S_SAMPLE: begin
        state_d = fault_q ? S_COMMIT : S_EXEC;
      end
      S_EXEC: begin
        if (wdt_trip)
          state_d = S_WAIT;
        else if (step_ack && last_step)
          state_d = S_COMMIT;
      end
      S_COMMIT: begin
        if (!t_zero)
          state_d = S_WAIT;
        else
          state_d = en ? S_SAMPLE : S_IDLE;
      end
      S_WAIT: begin
        if (t_zero)
          state_d = en ? S_SAMPLE : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= S_IDLE;
      timer_q  <= '0;
      pc_q     <= '0;
      in_q     <= '0;
      uo_q     <= '0;
      strobe_q <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q <= state_d;

      if (state_d == S_SAMPLE)
        timer_q <= RELOAD;
      else if (state_q != S_IDLE && !t_zero)
        timer_q <= timer_q - PERIOD_W'(1);

      if (state_q == S_SAMPLE) begin
        in_q <= ui_in;
        pc_q <= '0;
      end else if (adv) begin
        pc_q <= pc_q + ADDR_W'(1);
      end

      strobe_q <= adv
                  || (state_q == S_SAMPLE
                  && state_d == S_EXEC);

      if (wdt_trip)
        uo_q <= '0;
      else if (state_q == S_COMMIT)
        uo_q <= fault_q ? '0 : out_image_d;

      // A set event in the same cycle beats clear.
      if (ovr_set)
        ovr_q <= 1'b1;
      else if (clr_flags)
        ovr_q <= 1'b0;
    end
  end

`ifdef VSLC_SCAN_WATCHDOG_EN
  localparam int WDT_W = $clog2(WDT_CYCLES + 1);

  logic [WDT_W-1:0] wdt_q;

  assign wdt_trip = in_exec && !step_ack
                    && (wdt_q == WDT_W'(WDT_CYCLES - 1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wdt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      if (in_exec && !step_ack && !wdt_trip)
        wdt_q <= wdt_q + WDT_W'(1);
      else
        wdt_q <= '0;

      if (wdt_trip)
        fault_q <= 1'b1;
      else if (clr_flags)
        fault_q <= 1'b0;
    end
  end
`else
  assign wdt_trip = 1'b0;
  assign fault_q  = 1'b0;
`endif

  assign in_image       = in_q;
  assign pc             = pc_q;
  assign step_req       = in_exec;
  assign addr_strobe    = strobe_q;
  assign uo_out         = uo_q;
  assign scan_cycle_clk = (state_q == S_SAMPLE)
                          || in_exec
                          || (state_q == S_COMMIT);
  assign overrun        = ovr_q;
  assign fault          = fault_q;

endmodule
